// File: rtl/mont_mul_responder_if.sv
// Start/done handshake bundle between the exponentiation controller and one
// Montgomery multiplier slot.
interface mont_mul_responder_if #(
   parameter int unsigned NBITS = 256
);
   logic             start;
   logic [NBITS-1:0] x;
   logic [NBITS-1:0] y;
   logic [NBITS-1:0] n;
   logic [NBITS-1:0] out;
   logic             done;

   modport master (
      output start, x, y, n,
      input  out, done
   );

   modport slave (
      input  start, x, y, n,
      output out, done
   );
endinterface

// File: rtl/mont_mul_responder.sv
// Radix-2 Montgomery multiplier: out = x*y*2^-NBITS mod n, launched on the
// falling edge of start, done held high with a stable result until relaunch.
module mont_mul_responder #(
   parameter int unsigned NBITS = 256,
   parameter int unsigned CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   mont_mul_responder_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(NBITS - 1);

   state_t             state_q;
   logic               start_q;
   logic [NBITS-1:0]   x_q;
   logic [NBITS-1:0]   y_q;
   logic [NBITS-1:0]   n_q;
   logic [NBITS+1:0]   acc_q;
   logic [NBITS+1:0]   acc_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [NBITS-1:0]   out_q;
   logic [NBITS-1:0]   out_d;
   logic               done_q;
   logic               launch;

   logic [NBITS+1:0]   t_add;
   logic [NBITS+1:0]   t_red;
   logic [NBITS+1:0]   n_ext;
   logic [NBITS+1:0]   diff;

   // x_q is shifted right each iteration so the current multiplier bit is always x_q[0]
   always_comb begin
      launch = start_q & ~bus.start;
      n_ext  = {2'b00, n_q};
      t_add  = acc_q + (x_q[0] ? {2'b00, y_q} : '0);
      t_red  = t_add[0] ? (t_add + n_ext) : t_add;
      acc_d  = t_red >> 1;
      diff   = acc_q - n_ext;
      out_d  = (acc_q >= n_ext) ? diff[NBITS-1:0] : acc_q[NBITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         start_q <= bus.start;
         if (launch) begin
            x_q     <= bus.x;
            y_q     <= bus.y;
            n_q     <= bus.n;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            state_q <= CALC;
         end else begin
            case (state_q)
               IDLE: begin
               end
               CALC: begin
                  acc_q <= acc_d;
                  x_q   <= x_q >> 1;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_IT) begin
                     state_q <= FIX;
                  end
               end
               FIX: begin
                  out_q   <= out_d;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.out  = out_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mont_mul_responder.sv
// Scoreboard bench: an 8-bit and a 256-bit instance driven with directed
// operands; a monitor checks result and latency on every done rise.
module tb_mont_mul_responder;

   logic        clk;
   logic        rst8;
   logic        rst256;
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_fail;

   typedef struct {
      logic [255:0] out;
      int unsigned  cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q256[$];

   mont_mul_responder_if #(.NBITS(8))   if8 ();
   mont_mul_responder_if #(.NBITS(256)) if256 ();

   mont_mul_responder #(.NBITS(8), .CNT_W(4)) dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (if8)
   );

   mont_mul_responder #(.NBITS(256), .CNT_W(8)) dut256 (
      .clk (clk),
      .rst (rst256),
      .bus (if256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done rise must match the oldest outstanding expectation
   logic done8_prev;
   logic done256_prev;
   initial begin
      done8_prev   = 1'b0;
      done256_prev = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (if8.done === 1'b1 && done8_prev !== 1'b1) begin
         if (q8.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done8: got done rise at cycle %0d expected none", cyc);
         end else begin
            e = q8.pop_front();
            chk("out8", 256'(if8.out), e.out);
            chk("lat8", 256'(cyc), 256'(e.cyc));
         end
      end
      done8_prev = if8.done;
      if (if256.done === 1'b1 && done256_prev !== 1'b1) begin
         if (q256.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done256: got done rise at cycle %0d expected none", cyc);
         end else begin
            e = q256.pop_front();
            chk("out256", if256.out, e.out);
            chk("lat256", 256'(cyc), 256'(e.cyc));
         end
      end
      done256_prev = if256.done;
   end

   task automatic launch8(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] nv,
                          input bit push, input logic [7:0] ev);
      exp_t e;
      @(posedge clk); #1;
      if8.start = 1'b1;
      if8.x = xv;
      if8.y = yv;
      if8.n = nv;
      @(posedge clk); #1;
      if8.start = 1'b0;
      if (push) begin
         e.out = 256'(ev);
         e.cyc = cyc + 10;
         q8.push_back(e);
      end
   endtask

   task automatic launch256(input logic [255:0] xv, input logic [255:0] yv, input logic [255:0] nv,
                            input bit push, input logic [255:0] ev);
      exp_t e;
      @(posedge clk); #1;
      if256.start = 1'b1;
      if256.x = xv;
      if256.y = yv;
      if256.n = nv;
      @(posedge clk); #1;
      if256.start = 1'b0;
      if (push) begin
         e.out = ev;
         e.cyc = cyc + 258;
         q256.push_back(e);
      end
   endtask

   task automatic wait8(input int unsigned budget);
      int unsigned k = 0;
      while (q8.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q8.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout8: got %0d pending expected 0", q8.size());
         q8.delete();
      end
   endtask

   task automatic wait256(input int unsigned budget);
      int unsigned k = 0;
      while (q256.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q256.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout256: got %0d pending expected 0", q256.size());
         q256.delete();
      end
   endtask

   logic [255:0] nbig;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nbig     = '1 - 256'd188;
      rst8     = 1'b1;
      rst256   = 1'b1;
      if8.start = 1'b0;   if8.x = '0;   if8.y = '0;   if8.n = '0;
      if256.start = 1'b0; if256.x = '0; if256.y = '0; if256.n = '0;
      repeat (3) @(posedge clk);
      #1;
      rst8   = 1'b0;
      rst256 = 1'b0;
      chk("rst_done8", 256'(if8.done), 256'(0));
      chk("rst_out8", 256'(if8.out), 256'(0));
      chk("rst_done256", 256'(if256.done), 256'(0));

      // start held low after reset must not launch
      repeat (20) @(posedge clk);
      #1;
      chk("idle_nolaunch8", 256'(if8.done), 256'(0));

      // 9*5*R^-1 mod 13 = 5, then no relaunch while start stays low
      launch8(8'd9, 8'd5, 8'd13, 1'b1, 8'd5);
      @(posedge clk); #1;
      chk("busy8", 256'(if8.done), 256'(0));
      wait8(50);
      repeat (20) @(posedge clk);
      #1;
      chk("hold_out8", 256'(if8.out), 256'(5));
      chk("hold_done8", 256'(if8.done), 256'(1));

      // back-to-back ops; done must drop between them
      launch8(8'd12, 8'd12, 8'd13, 1'b1, 8'd3);
      wait8(50);
      launch8(8'd0, 8'd7, 8'd13, 1'b1, 8'd0);
      @(posedge clk); #1;
      chk("gap_done8", 256'(if8.done), 256'(0));
      wait8(50);

      // operand changes while idle are ignored
      if8.x = 8'hFF; if8.y = 8'hA5; if8.n = 8'h07;
      repeat (15) @(posedge clk);
      #1;
      chk("idle_out8", 256'(if8.out), 256'(0));
      chk("idle_done8", 256'(if8.done), 256'(1));

      // relaunch at cycle 4 of a running op; only the second one completes
      launch8(8'd9, 8'd5, 8'd13, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      launch8(8'd9, 8'd11, 8'd13, 1'b1, 8'd11);
      wait8(50);

      // 256-bit: x = R mod n makes the result equal y
      launch256(256'd189, 256'd7, nbig, 1'b1, 256'd7);
      wait256(300);
      launch256(256'd1, 256'd189, nbig, 1'b1, 256'd1);
      wait256(300);

      // reset mid-operation
      launch256(256'd5, 256'd9, nbig, 1'b0, 256'd0);
      repeat (50) @(posedge clk);
      #1;
      rst256 = 1'b1;
      @(posedge clk); #1;
      rst256 = 1'b0;
      chk("midrst_done256", 256'(if256.done), 256'(0));
      chk("midrst_out256", if256.out, 256'(0));
      repeat (300) @(posedge clk);
      #1;
      chk("postrst_done256", 256'(if256.done), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
